icache_direct: RTL and testbench

Direct-mapped, 16-frame, one-word-per-block instruction cache. It sits between the pipeline fetch stage and the memory controller. It serves `imemaddr` lookups, using the `icachef_t` split of tag[31:6], idx[5:2] and bytoff[1:0]. On a miss it fills from the memory controller's instruction port.

---
 rtl/icache_direct.sv | 120 ++++++++++++
 tb/tb_icache_direct.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/icache_direct.sv
// Direct-mapped 16-frame instruction cache, one 32-bit word per frame, single fill port.
// Optional ICACHE_STATS_EN adds free-running hit/miss counters as extra outputs.
module icache_direct (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  output logic        ihit,
  output logic [31:0] imemload,
  input  logic        iflush,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        iwait,
  input  logic [31:0] iload
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
`endif
);

  localparam int ITAG_W = 26;
  localparam int IIDX_W = 4;
  localparam int WORD_W = 32;
  localparam int FRAMES = 1 << IIDX_W;

  typedef enum logic {IDLE, FETCH} state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [FRAMES-1:0]   r_valid;
  logic [ITAG_W-1:0]   r_tag  [FRAMES];
  logic [WORD_W-1:0]   r_data [FRAMES];
  logic [WORD_W-1:0]   r_miss_addr;
  logic [WORD_W-1:0]   w_miss_addr_next;
  logic [IIDX_W-1:0]   w_idx;
  logic [IIDX_W-1:0]   w_fill_idx;
  logic [ITAG_W-1:0]   w_tag;
  logic                w_hit;
  logic                w_fill;
  logic                w_unused;

  assign w_idx      = imemaddr[5:2];
  assign w_tag      = imemaddr[31:6];
  assign w_fill_idx = r_miss_addr[5:2];
  assign w_hit      = imemREN && r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign imemload   = r_data[w_idx];
  assign w_unused   = &{1'b0, imemaddr[1:0]};

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state     <= IDLE;
      r_miss_addr <= '0;
    end else begin
      r_state     <= w_state_next;
      r_miss_addr <= w_miss_addr_next;
    end
  end

  always_comb begin
    w_state_next     = r_state;
    w_miss_addr_next = r_miss_addr;
    ihit             = 1'b0;
    iREN             = 1'b0;
    iaddr            = '0;
    w_fill           = 1'b0;
    case (r_state)
      IDLE: begin
        ihit = w_hit;
        if (imemREN && !w_hit) begin
          w_state_next     = FETCH;
          w_miss_addr_next = {imemaddr[31:2], 2'b00};
        end
      end
      FETCH: begin
        iREN  = 1'b1;
        iaddr = r_miss_addr;
        // A flush abandons the outstanding fill so stale data can never become valid.
        if (iflush) begin
          w_state_next = IDLE;
        end else if (!iwait) begin
          w_fill       = 1'b1;
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_valid <= '0;
    end else if (iflush) begin
      r_valid <= '0;
    end else if (w_fill) begin
      r_valid[w_fill_idx] <= 1'b1;
    end
  end

  // Tag/data carry no reset; the valid bits alone decide whether a frame is usable.
  always_ff @(posedge CLK) begin
    if (w_fill) begin
      r_tag[w_fill_idx]  <= r_miss_addr[31:6];
      r_data[w_fill_idx] <= iload;
    end
  end

`ifdef ICACHE_STATS_EN
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (ihit) hit_count <= hit_count + 32'd1;
      if (r_state == IDLE && w_state_next == FETCH) miss_count <= miss_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_icache_direct.sv
// Randomized plus directed bench for icache_direct against a per-frame behavioural model.
// Counter checks are included when ICACHE_STATS_EN is defined.
module tb_icache_direct;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        ihit;
  logic [31:0] imemload;
  logic        iflush;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;
`ifdef ICACHE_STATS_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;
`endif

  icache_direct dut (
    .CLK      (CLK),
    .nRST     (nRST),
    .imemREN  (imemREN),
    .imemaddr (imemaddr),
    .ihit     (ihit),
    .imemload (imemload),
    .iflush   (iflush),
    .iREN     (iREN),
    .iaddr    (iaddr),
    .iwait    (iwait),
    .iload    (iload)
`ifdef ICACHE_STATS_EN
    ,
    .hit_count  (hit_count),
    .miss_count (miss_count)
`endif
  );

  always #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: each frame remembers the full word address it caches and the word itself.
  bit          m_v    [16];
  logic [31:0] m_addr [16];
  logic [31:0] m_data [16];
  bit          m_fetch;
  logic [31:0] m_maddr;
  int          m_hits;
  int          m_misses;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit model_hit(input bit req, input logic [31:0] addr);
    logic [3:0] i;
    i = addr[5:2];
    return req && m_v[i] && (m_addr[i][31:6] == addr[31:6]);
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 16; i++) m_v[i] = 1'b0;
  endtask

  // One clock: apply inputs, check outputs mid-cycle, then advance the model at the edge.
  task automatic step(input bit req, input logic [31:0] addr, input bit fl,
                      input bit wt, input logic [31:0] ld);
    bit          eh;
    logic [31:0] a;
    a        = addr;
    imemREN  = req;
    imemaddr = a;
    iflush   = fl;
    iwait    = wt;
    iload    = ld;
    @(negedge CLK);
    eh = !m_fetch && model_hit(req, a);
    check_eq("ihit", {31'd0, ihit}, {31'd0, eh});
    check_eq("iREN", {31'd0, iREN}, {31'd0, m_fetch});
    check_eq("iaddr", iaddr, m_fetch ? m_maddr : 32'd0);
    if (eh) check_eq("imemload", imemload, m_data[a[5:2]]);
    @(posedge CLK);
    if (!m_fetch) begin
      if (eh) m_hits++;
      if (fl) model_clear();
      if (req && !eh) begin
        m_fetch = 1'b1;
        m_maddr = {a[31:2], 2'b00};
        m_misses++;
      end
    end else if (fl) begin
      model_clear();
      m_fetch = 1'b0;
    end else if (!wt) begin
      m_v[m_maddr[5:2]]    = 1'b1;
      m_addr[m_maddr[5:2]] = m_maddr;
      m_data[m_maddr[5:2]] = ld;
      m_fetch              = 1'b0;
    end
    #1;
  endtask

  task automatic do_reset();
    nRST = 1'b0;
    #1;
    check_eq("rst_iREN", {31'd0, iREN}, 32'd0);
    check_eq("rst_iaddr", iaddr, 32'd0);
    check_eq("rst_ihit", {31'd0, ihit}, 32'd0);
    model_clear();
    m_fetch  = 1'b0;
    m_maddr  = '0;
    m_hits   = 0;
    m_misses = 0;
`ifdef ICACHE_STATS_EN
    check_eq("rst_hit_count", hit_count, 32'd0);
    check_eq("rst_miss_count", miss_count, 32'd0);
`endif
    @(posedge CLK);
    #1;
    nRST = 1'b1;
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] tagv;
    nRST     = 1'b0;
    imemREN  = 1'b0;
    imemaddr = '0;
    iflush   = 1'b0;
    iwait    = 1'b1;
    iload    = '0;
    @(posedge CLK);
    #1;
    do_reset();

    // Basic miss with one wait cycle, then a hit on the filled word.
    step(1, 32'h40, 0, 1, 32'h0);
    step(1, 32'h40, 0, 1, 32'h0);
    step(1, 32'h40, 0, 0, 32'h2002_0005);
    step(1, 32'h40, 0, 1, 32'h0);

    // Conflict eviction on index 0.
    step(1, 32'h440, 0, 1, 32'h0);
    step(1, 32'h440, 0, 0, 32'hDEAD_BEEF);
    step(1, 32'h440, 0, 1, 32'h0);
    step(1, 32'h40, 0, 1, 32'h0);
    step(1, 32'h40, 0, 0, 32'h2002_0005);
    step(1, 32'h40, 0, 1, 32'h0);

    // Redirect during FETCH: the fill still lands at the latched miss address.
    step(1, 32'h80, 0, 1, 32'h0);
    step(1, 32'h100, 0, 1, 32'h0);
    step(1, 32'h100, 0, 0, 32'hAAAA_0080);
    step(1, 32'h100, 0, 1, 32'h0);
    step(1, 32'h100, 0, 0, 32'hBBBB_0100);
    step(1, 32'h100, 0, 1, 32'h0);
    step(0, 32'h80, 0, 1, 32'h0);

    // Fill four frames, flush, then all four miss again.
    for (int k = 0; k < 4; k++) begin
      step(1, 32'h1000 + 32'(k * 4), 0, 0, 32'hC000_0000 + 32'(k));
      step(1, 32'h1000 + 32'(k * 4), 0, 0, 32'hC000_0000 + 32'(k));
      step(1, 32'h1000 + 32'(k * 4), 0, 1, 32'h0);
    end
    step(0, 32'h0, 1, 1, 32'h0);
    for (int k = 0; k < 4; k++) begin
      step(1, 32'h1000 + 32'(k * 4), 0, 0, 32'hD000_0000 + 32'(k));
      step(1, 32'h1000 + 32'(k * 4), 0, 0, 32'hD000_0000 + 32'(k));
      step(1, 32'h1000 + 32'(k * 4), 0, 1, 32'h0);
    end

    // Reset asserted while a fill is pending.
    step(1, 32'h200, 0, 1, 32'h0);
    step(1, 32'h200, 0, 1, 32'h0);
    do_reset();
    step(1, 32'h200, 0, 1, 32'h0);
    step(1, 32'h200, 0, 0, 32'h1234_5678);
    step(1, 32'h200, 0, 1, 32'h0);

    // Flush coinciding with the fill cycle suppresses the write.
    step(1, 32'h300, 0, 1, 32'h0);
    step(1, 32'h300, 1, 0, 32'h5555_5555);
    step(1, 32'h300, 0, 1, 32'h0);
    step(1, 32'h300, 0, 0, 32'h6666_6666);
    step(1, 32'h300, 0, 1, 32'h0);

    // Random traffic over a few tags per index so hits, conflicts and redirects all occur.
    a = 32'h0;
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 9) < 3 || n == 0) begin
        tagv = ($urandom_range(0, 3) == 3) ? 32'h03FF_FFFF : 32'($urandom_range(0, 2));
        a = (tagv << 6) | (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
      end
      step($urandom_range(0, 9) < 8, a, $urandom_range(0, 39) == 0,
           $urandom_range(0, 9) < 4, $urandom);
    end

`ifdef ICACHE_STATS_EN
    check_eq("hit_count", hit_count, 32'(m_hits));
    check_eq("miss_count", miss_count, 32'(m_misses));
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
